sap_exec_unit: RTL and testbench

SAP_EXEC_UNIT -- requirements
Module: sap_exec_unit

---
 rtl/sap_exec_unit.sv | 213 +++++++++++++++++++++
 tb/tb_sap_exec_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sap_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : sap_exec_unit
// Purpose  : SAP-1 style execution unit. Holds the T1..T6 ring counter, the
//            instruction decoder that produces the 12-bit control word, the
//            accumulator and the add/subtract ALU with its bus driver.
// Ports    : clock        - rising-edge clock for all state
//            reset        - synchronous active-high reset
//            instruction  - opcode nibble from the instruction register
//            w_bus        - W-bus value; accumulator load source
//            b_reg        - B register value; ALU operand B
//            control_word - {Cp,Ep,Lm_n,Ce_n,Li_n,Ei_n,La_n,Ea,Su,Eu,Lb_n,Lo_n}
//            ula_input    - accumulator contents; ALU operand A
//            bus_out      - value driven onto the W-bus
//            bus_oe       - bus_out valid (Ea or Eu high)
//            t_state      - one-hot ring counter, bit0 = T1 ... bit5 = T6
//            carry_flag   - ALU carry-out captured on ALU load (SAP_FLAGS_EN)
//            zero_flag    - ALU result == 0 captured on ALU load (SAP_FLAGS_EN)
//            halted       - high after HLT executes
// Config   : define SAP_FLAGS_EN to add the carry/zero flag registers/ports.
// Revision : 1.0 - initial release
// ============================================================================
module sap_exec_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  instruction,
  input  logic [7:0]  w_bus,
  input  logic [7:0]  b_reg,
  output logic [11:0] control_word,
  output logic [7:0]  ula_input,
  output logic [7:0]  bus_out,
  output logic        bus_oe,
  output logic [5:0]  t_state,
`ifdef SAP_FLAGS_EN
  output logic        carry_flag,
  output logic        zero_flag,
`endif
  output logic        halted
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [11:0] CW_IDLE    = 12'h3E3;
  localparam logic [11:0] CW_FETCH1  = 12'h5E3;  // Ep, Lm_n
  localparam logic [11:0] CW_FETCH2  = 12'hBE3;  // Cp
  localparam logic [11:0] CW_FETCH3  = 12'h263;  // Ce_n, Li_n
  localparam logic [11:0] CW_ADDR    = 12'h1A3;  // Lm_n, Ei_n
  localparam logic [11:0] CW_LDA_T5  = 12'h2C3;  // Ce_n, La_n
  localparam logic [11:0] CW_LDB_T5  = 12'h2E1;  // Ce_n, Lb_n
  localparam logic [11:0] CW_ADD_T6  = 12'h3C7;  // La_n, Eu
  localparam logic [11:0] CW_SUB_T6  = 12'h3CF;  // La_n, Su, Eu
  localparam logic [11:0] CW_OUT_T4  = 12'h3F2;  // Ea, Lo_n

  tstate_e     state;
  tstate_e     next_state;
  logic [7:0]  acc;
  logic [7:0]  alu_b;
  logic [7:0]  alu_result;
  logic        la_n;
  logic        ea;
  logic        su;
  logic        eu;

  assign la_n = control_word[5];
  assign ea   = control_word[4];
  assign su   = control_word[3];
  assign eu   = control_word[2];

  // --------------------------------------------------------------------------
  // Ring counter state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= T1;
    end else begin
      state <= next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and control word decode. The opcode is only consulted in
  // T4..T6, so IR changes during fetch cannot disturb the fetch words.
  // HLT holds the counter at T4: the halting edge is also the freezing edge.
  // --------------------------------------------------------------------------
  always_comb begin
    next_state   = state;
    control_word = CW_IDLE;
    if (!halted) begin
      case (state)
        T1: begin
          next_state   = T2;
          control_word = CW_FETCH1;
        end
        T2: begin
          next_state   = T3;
          control_word = CW_FETCH2;
        end
        T3: begin
          next_state   = T4;
          control_word = CW_FETCH3;
        end
        T4: begin
          next_state = (instruction == OP_HLT) ? T4 : T5;
          case (instruction)
            OP_LDA, OP_ADD, OP_SUB: control_word = CW_ADDR;
            OP_OUT:                 control_word = CW_OUT_T4;
            default:                control_word = CW_IDLE;
          endcase
        end
        T5: begin
          next_state = T6;
          case (instruction)
            OP_LDA:         control_word = CW_LDA_T5;
            OP_ADD, OP_SUB: control_word = CW_LDB_T5;
            default:        control_word = CW_IDLE;
          endcase
        end
        T6: begin
          next_state = T1;
          case (instruction)
            OP_ADD:  control_word = CW_ADD_T6;
            OP_SUB:  control_word = CW_SUB_T6;
            default: control_word = CW_IDLE;
          endcase
        end
        default: begin
          next_state   = T1;
          control_word = CW_IDLE;
        end
      endcase
    end
  end

  assign t_state = state;

  // --------------------------------------------------------------------------
  // Halt latch: set at the T4 edge of HLT, cleared only by reset
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      halted <= 1'b0;
    end else if (!halted && (state == T4) && (instruction == OP_HLT)) begin
      halted <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Accumulator
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      acc <= 8'h00;
    end else if (!la_n) begin
      acc <= w_bus;
    end
  end

  assign ula_input = acc;

  // --------------------------------------------------------------------------
  // ALU: subtraction is A + ~B + 1 (two's complement), wrapping mod 256
  // --------------------------------------------------------------------------
  assign alu_b = su ? ~b_reg : b_reg;

`ifdef SAP_FLAGS_EN
  logic [8:0] alu_sum;

  assign alu_sum    = {1'b0, acc} + {1'b0, alu_b} + {8'b0, su};
  assign alu_result = alu_sum[7:0];

  // Flags track only ALU results written back, not LDA loads.
  always_ff @(posedge clock) begin
    if (reset) begin
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
    end else if (!la_n && eu) begin
      carry_flag <= alu_sum[8];
      zero_flag  <= (alu_sum[7:0] == 8'h00);
    end
  end
`else
  assign alu_result = acc + alu_b + {7'b0, su};
`endif

  // --------------------------------------------------------------------------
  // Bus driver: Ea and Eu are mutually exclusive in every legal word
  // --------------------------------------------------------------------------
  always_comb begin
    bus_out = 8'h00;
    if (ea) begin
      bus_out = acc;
    end else if (eu) begin
      bus_out = alu_result;
    end
  end

  assign bus_oe = ea | eu;

endmodule
`default_nettype wire

// File: tb/tb_sap_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_sap_exec_unit
// Purpose  : Directed self-checking bench for sap_exec_unit. The W-bus is
//            modelled as the DUT's own driver when bus_oe is high, otherwise
//            the bench's memory data value.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sap_exec_unit;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_NOP = 4'b0101;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  logic        clock;
  logic        reset;
  logic [3:0]  instruction;
  logic [7:0]  w_bus;
  logic [7:0]  b_reg;
  logic [7:0]  mem_data;
  logic [11:0] control_word;
  logic [7:0]  ula_input;
  logic [7:0]  bus_out;
  logic        bus_oe;
  logic [5:0]  t_state;
  logic        halted;
`ifdef SAP_FLAGS_EN
  logic        carry_flag;
  logic        zero_flag;
`endif

  int checks = 0;
  int errors = 0;

  logic [5:0]  ts_exp [6] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20};
  logic [11:0] cw_exp [6] = '{12'h5E3, 12'hBE3, 12'h263, 12'h1A3, 12'h2C3, 12'h3E3};

  assign w_bus = bus_oe ? bus_out : mem_data;

  sap_exec_unit dut (
    .clock        (clock),
    .reset        (reset),
    .instruction  (instruction),
    .w_bus        (w_bus),
    .b_reg        (b_reg),
    .control_word (control_word),
    .ula_input    (ula_input),
    .bus_out      (bus_out),
    .bus_oe       (bus_oe),
    .t_state      (t_state),
`ifdef SAP_FLAGS_EN
    .carry_flag   (carry_flag),
    .zero_flag    (zero_flag),
`endif
    .halted       (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Runs one full six-state instruction starting and ending at T1.
  task automatic run_op(input logic [3:0] op, input logic [7:0] d, input logic [7:0] b);
    instruction = op;
    mem_data    = d;
    b_reg       = b;
    tick_n(6);
  endtask

  initial begin
    reset       = 1'b1;
    instruction = OP_LDA;
    mem_data    = 8'h00;
    b_reg       = 8'h00;
    tick_n(1);
    check("rst_tstate", 16'(t_state), 16'h0001);
    check("rst_acc", 16'(ula_input), 16'h0000);
    check("rst_halted", 16'(halted), 16'h0000);
    check("rst_cw_t1", 16'(control_word), 16'h05E3);
    reset = 1'b0;

    // Free-running LDA sequence, loads 0x0A
    mem_data = 8'h0A;
    for (int i = 0; i < 6; i++) begin
      check("seq_tstate", 16'(t_state), 16'(ts_exp[i]));
      check("seq_cw", 16'(control_word), 16'(cw_exp[i]));
      tick_n(1);
    end
    check("seq_wrap_tstate", 16'(t_state), 16'h0001);
    check("lda_acc", 16'(ula_input), 16'h000A);

    // ADD 0x0A + 0x08
    instruction = OP_ADD;
    b_reg       = 8'h08;
    tick_n(5);
    check("add_cw_t6", 16'(control_word), 16'h03C7);
    check("add_bus", 16'(bus_out), 16'h0012);
    check("add_oe", 16'(bus_oe), 16'h0001);
    tick_n(1);
    check("add_acc", 16'(ula_input), 16'h0012);
    check("add_next_t1", 16'(t_state), 16'h0001);

    // ADD with wrap: 0x12 + 0xF0 = 0x102
    instruction = OP_ADD;
    b_reg       = 8'hF0;
    tick_n(5);
    check("addwrap_bus", 16'(bus_out), 16'h0002);
    tick_n(1);
    check("addwrap_acc", 16'(ula_input), 16'h0002);
`ifdef SAP_FLAGS_EN
    check("addwrap_carry", 16'(carry_flag), 16'h0001);
    check("addwrap_zero", 16'(zero_flag), 16'h0000);
`endif

    // SUB 0x03 - 0x05 = 0xFE (borrow)
    run_op(OP_LDA, 8'h03, 8'h00);
    check("lda3_acc", 16'(ula_input), 16'h0003);
    instruction = OP_SUB;
    b_reg       = 8'h05;
    tick_n(5);
    check("sub_cw_t6", 16'(control_word), 16'h03CF);
    check("sub_bus", 16'(bus_out), 16'h00FE);
    tick_n(1);
    check("sub_acc", 16'(ula_input), 16'h00FE);
`ifdef SAP_FLAGS_EN
    check("sub_carry", 16'(carry_flag), 16'h0000);
    check("sub_zero", 16'(zero_flag), 16'h0000);
`endif

    // SUB 0x04 - 0x04 = 0x00 (no borrow, zero)
    run_op(OP_LDA, 8'h04, 8'h00);
    instruction = OP_SUB;
    b_reg       = 8'h04;
    tick_n(5);
    check("subz_bus", 16'(bus_out), 16'h0000);
    check("subz_oe", 16'(bus_oe), 16'h0001);
    tick_n(1);
    check("subz_acc", 16'(ula_input), 16'h0000);
`ifdef SAP_FLAGS_EN
    check("subz_carry", 16'(carry_flag), 16'h0001);
    check("subz_zero", 16'(zero_flag), 16'h0001);
`endif

    // NOP 0101 with opcode wiggling during fetch
    run_op(OP_LDA, 8'h5A, 8'h00);
    mem_data    = 8'hC3;
    instruction = OP_OUT;
    check("fetch_t1_ign", 16'(control_word), 16'h05E3);
    tick_n(1);
    instruction = OP_HLT;
    check("fetch_t2_ign", 16'(control_word), 16'h0BE3);
    tick_n(1);
    instruction = OP_ADD;
    check("fetch_t3_ign", 16'(control_word), 16'h0263);
    instruction = OP_NOP;
    tick_n(1);
    for (int i = 0; i < 3; i++) begin
      check("nop_cw", 16'(control_word), 16'h03E3);
      check("nop_oe", 16'(bus_oe), 16'h0000);
      tick_n(1);
    end
    check("nop_acc", 16'(ula_input), 16'h005A);
    check("nop_halted", 16'(halted), 16'h0000);

    // Program: LDA 0A, ADD 08, ADD 02, SUB 04, OUT, HLT
    reset = 1'b1;
    tick_n(1);
    reset = 1'b0;
    run_op(OP_LDA, 8'h0A, 8'h00);
    run_op(OP_ADD, 8'h08, 8'h08);
    run_op(OP_ADD, 8'h02, 8'h02);
    run_op(OP_SUB, 8'h04, 8'h04);
    check("prog_acc", 16'(ula_input), 16'h0010);
    instruction = OP_OUT;
    tick_n(3);
    check("out_cw_t4", 16'(control_word), 16'h03F2);
    check("out_bus", 16'(bus_out), 16'h0010);
    check("out_oe", 16'(bus_oe), 16'h0001);
    tick_n(3);
    instruction = OP_HLT;
    tick_n(3);
    check("hlt_cw_t4", 16'(control_word), 16'h03E3);
    check("hlt_pre", 16'(halted), 16'h0000);
    tick_n(1);
    for (int i = 0; i < 20; i++) begin
      check("hlt_halted", 16'(halted), 16'h0001);
      check("hlt_cw", 16'(control_word), 16'h03E3);
      check("hlt_tstate", 16'(t_state), 16'h0008);
      tick_n(1);
    end

    // Reset at T5 of ADD aborts the instruction
    reset = 1'b1;
    tick_n(1);
    reset = 1'b0;
    check("unhalt", 16'(halted), 16'h0000);
    run_op(OP_LDA, 8'h33, 8'h00);
    instruction = OP_ADD;
    b_reg       = 8'h01;
    tick_n(4);
    check("midrst_at_t5", 16'(t_state), 16'h0010);
    reset = 1'b1;
    tick_n(1);
    reset = 1'b0;
    check("midrst_tstate", 16'(t_state), 16'h0001);
    check("midrst_acc", 16'(ula_input), 16'h0000);
    check("midrst_halted", 16'(halted), 16'h0000);

    // Reset beats an accumulator load (LDA T5)
    instruction = OP_LDA;
    mem_data    = 8'h44;
    tick_n(4);
    reset = 1'b1;
    tick_n(1);
    reset = 1'b0;
    check("rstload_acc", 16'(ula_input), 16'h0000);

    // Reset beats halt (HLT T4)
    instruction = OP_HLT;
    tick_n(3);
    reset = 1'b1;
    tick_n(1);
    reset = 1'b0;
    check("rsthlt_halted", 16'(halted), 16'h0000);
    check("rsthlt_tstate", 16'(t_state), 16'h0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
